demux_rr_dispatch: RTL and testbench

//   Sequences a 1-to-N demultiplexer datapath: accepts words from one valid/ready source and

---
 rtl/demux_dispatch_pkg.sv | 15 +
 rtl/demux_rr_dispatch_onehot_dec.sv | 18 +
 rtl/demux_rr_dispatch.sv | 108 ++++++++++
 tb/tb_demux_rr_dispatch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the round-robin / fixed-target demux dispatcher.
// The optional transfer counters are enabled with DEMUX_DISPATCH_CNT_EN.
package demux_dispatch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/demux_rr_dispatch_onehot_dec.sv
// Select-to-one-hot decoder; all outputs low while disabled.
module onehot_dec #(
    parameter int N_OUT = 8,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_rr_dispatch.sv
// 1-to-N_OUT dispatcher: holds one source word and strobes it to a round-robin or fixed sink.
// Define DEMUX_DISPATCH_CNT_EN to add per-sink 16-bit transfer counters on xfer_cnt.
module demux_rr_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 8,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  cfg_sel,
    output logic [SEL_W-1:0]  sel,
    output logic [N_OUT-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [N_OUT-1:0]  out_ready,
    output logic              busy
`ifdef DEMUX_DISPATCH_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0] xfer_cnt
`endif
);

    // Valid/ready: a word moves on any cycle where valid and ready are both high at the
    // rising edge; the sender keeps valid and data stable until that happens.

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] hold_q;
    logic              mode_q;
    logic              complete;
    logic              accept;

    assign busy     = (state_q == ST_SEND);
    assign complete = busy & out_ready[sel_q];
    assign in_ready = ~busy | complete;
    assign accept   = in_valid & in_ready;
    assign sel      = sel_q;
    assign out_data = hold_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (complete && mode_q == MODE_RR) begin
            rr_ptr_d = rr_ptr_q + SEL_W'(1);
        end
        if (accept) begin
            state_d = ST_SEND;
        end else if (complete) begin
            state_d = ST_IDLE;
        end
    end

    // A word accepted on the completing edge targets the already-advanced pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            hold_q   <= '0;
            mode_q   <= MODE_RR;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                hold_q <= in_data;
                mode_q <= mode;
                sel_q  <= (mode == MODE_FIXED) ? cfg_sel : rr_ptr_d;
            end
        end
    end

    onehot_dec #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_dec (
        .en     (busy),
        .sel    (sel_q),
        .onehot (out_valid)
    );

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (complete) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            xfer_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch: cycle model, delivery scoreboard, literal checks.
module tb_demux_rr_dispatch;

    localparam int DATA_W = 8;
    localparam int N_OUT  = 8;
    localparam int SEL_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mode;
    logic [SEL_W-1:0]  cfg_sel;
    logic [SEL_W-1:0]  sel;
    logic [N_OUT-1:0]  out_valid;
    logic [DATA_W-1:0] out_data;
    logic [N_OUT-1:0]  out_ready;
    logic              busy;
`ifdef DEMUX_DISPATCH_CNT_EN
    logic [N_OUT*16-1:0] xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    demux_rr_dispatch #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .cfg_sel   (cfg_sel),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef DEMUX_DISPATCH_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Holds "which word is pending and where it must go"; the rotating target is
    // the number of round-robin completions so far, modulo N_OUT.
    logic       m_busy;
    int         m_sel;
    logic [7:0] m_data;
    logic       m_mode;
    int         m_rr_count;
    logic       m_compl, m_acc;
    int         m_next_rr;

    assign m_compl   = m_busy && out_ready[m_sel];
    assign m_acc     = in_valid && (!m_busy || m_compl);
    assign m_next_rr = (m_compl && m_mode == 1'b0) ? m_rr_count + 1 : m_rr_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_sel      <= 0;
            m_data     <= '0;
            m_mode     <= 1'b0;
            m_rr_count <= 0;
        end else begin
            m_rr_count <= m_next_rr;
            if (m_acc) begin
                m_busy <= 1'b1;
                m_data <= in_data;
                m_mode <= mode;
                m_sel  <= mode ? int'(cfg_sel) : (m_next_rr % N_OUT);
            end else if (m_compl) begin
                m_busy <= 1'b0;
            end
        end
    end

    // per-cycle compare against the model
    logic check_en = 1'b0;
    always @(negedge clk) begin
        if (rst_n && check_en) begin
            check("cyc_out_valid", 32'(out_valid), m_busy ? 32'(1 << m_sel) : 32'd0);
            check("cyc_out_data", 32'(out_data), 32'(m_data));
            check("cyc_sel", 32'(sel), 32'(m_sel));
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_in_ready", 32'(in_ready), 32'(!m_busy || out_ready[m_sel]));
        end
    end

    // ---------------- delivery scoreboard ----------------
    logic [15:0] exp_q[$];   // {sink, data}

    always @(posedge clk) begin
        if (rst_n) begin
            int hits;
            logic [15:0] got;
            hits = 0;
            got  = '0;
            for (int i = 0; i < N_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    hits++;
                    got = {8'(i), out_data};
                end
            end
            if (hits > 1) check("deliver_multi", 32'(hits), 32'd1);
            if (hits == 1) begin
                if (exp_q.size() == 0) begin
                    check("deliver_unexpected", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    check("deliver", 32'(got), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] d, input int sink, input logic m, input int cs,
                        input bit expect_delivery = 1'b1);
        int budget;
        mode     = m;
        cfg_sel  = SEL_W'(cs);
        in_data  = d;
        in_valid = 1'b1;
        if (expect_delivery) exp_q.push_back({8'(sink), d});
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (budget >= 50) check("accept_timeout", 32'(budget), 32'd0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        cfg_sel   = '0;
        out_ready = '1;
        #13;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check_en = 1'b1;

        // 1: round robin A0..A7 to sinks 0..7, then 9th word wraps to sink 0
        for (int i = 0; i < 8; i++) begin
            send(8'hA0 + 8'(i), i, 1'b0, 0);
            if (i == 3) begin
                #1;
                check("t1_sel3", 32'(sel), 32'd3);
                check("t1_valid3", 32'(out_valid), 32'h08);
            end
        end
        send(8'hB8, 0, 1'b0, 0);
        #1;
        check("t1_wrap_sel", 32'(sel), 32'd0);
        check("t1_wrap_data", 32'(out_data), 32'hB8);
        idle_cycles(2);
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        check("t1_idle_sel_held", 32'(sel), 32'd0);
        check("t1_idle_data_held", 32'(out_data), 32'hB8);

        // 2: fixed target 5, stalled 4 cycles; cfg_sel change mid-hold ignored
        out_ready = 8'h00;
        send(8'h55, 5, 1'b1, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_valid_held", 32'(out_valid), 32'b0010_0000);
            check("t2_data_held", 32'(out_data), 32'h55);
            check("t2_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #2;
            if (i == 1) cfg_sel = 3'd2;
        end
        out_ready = 8'hFF;
        idle_cycles(2);
        check("t2_done_busy", 32'(busy), 32'd0);

        // 3: target 3, every other sink ready -> no completion
        out_ready = 8'b1111_0111;
        send(8'h33, 3, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_busy", 32'(busy), 32'd1);
            check("t3_valid", 32'(out_valid), 32'b0000_1000);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #2;
        end
        out_ready = 8'hFF;
        idle_cycles(1);
        // fixed mode left the pointer at 1
        send(8'h11, 1, 1'b0, 6);
        idle_cycles(1);

        // 4: back-to-back, no bubble; pointer now 2
        for (int i = 0; i < 5; i++) begin
            send(8'hC0 + 8'(i), 2 + i, 1'b0, 0);
            if (i > 0) check("t4_no_bubble", 32'(busy), 32'd1);
        end
        idle_cycles(2);

        // 5: reset while a word to sink 7 is held
        out_ready = 8'h00;
        send(8'h77, 7, 1'b0, 0, 1'b0);
        #1;
        check("t5_pre_valid", 32'(out_valid), 32'h80);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_sel", 32'(sel), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        send(8'h99, 0, 1'b0, 0);
        #1;
        check("t5_after_sel", 32'(sel), 32'd0);
        idle_cycles(2);

`ifdef DEMUX_DISPATCH_CNT_EN
        // 6: counters on sink 2, including wrap
        for (int i = 0; i < 3; i++) send(8'h20 + 8'(i), 2, 1'b1, 2);
        idle_cycles(1);
        check("t6_cnt3", 32'(xfer_cnt[2*16 +: 16]), 32'd3);
        check("t6_cnt0", 32'(xfer_cnt[0 +: 16]), 32'd1);
        for (int i = 0; i < 65532; i++) send(8'(i), 2, 1'b1, 2);
        idle_cycles(1);
        check("t6_cnt_max", 32'(xfer_cnt[2*16 +: 16]), 32'hFFFF);
        send(8'hEE, 2, 1'b1, 2);
        idle_cycles(1);
        check("t6_cnt_wrap", 32'(xfer_cnt[2*16 +: 16]), 32'd0);
`endif

        idle_cycles(3);
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
